// File: rtl/tuse_tnew_scoreboard.sv
// Purpose : D-stage Tuse/Tnew hazard scoreboard; tracks in-flight GPR writers
//           and reports stall plus the producer-stage tag for rs/rt forwarding.
// Latency : stall/fwd tags are combinational from registered state; issue and
//           advance take effect on the next rising edge; busy_cnt is registered.
// Backpressure: stall freezes only F/D; tracked writers keep advancing
//           through E/M/W every cycle regardless of stall.
// Ports   : clk, rst_n (async, active-low)
//           id_valid/id_rs/id_rt/id_tuse_rs/id_tuse_rt - D-stage operand reads
//           id_we/id_dst/id_tnew                       - D-stage writer to issue
//           stall, fwd_rs_src, fwd_rt_src (0=GRF,1=E,2=M,3=W), busy_cnt
module tuse_tnew_scoreboard #(
   parameter int NREG   = 32,
   parameter int TW     = 2,
   parameter int NSTAGE = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic [4:0]    id_rs,
   input  logic [4:0]    id_rt,
   input  logic [TW-1:0] id_tuse_rs,
   input  logic [TW-1:0] id_tuse_rt,
   input  logic          id_we,
   input  logic [4:0]    id_dst,
   input  logic [TW-1:0] id_tnew,
   output logic          stall,
   output logic [1:0]    fwd_rs_src,
   output logic [1:0]    fwd_rt_src,
   output logic [5:0]    busy_cnt
);

   // All-ones Tuse means the operand is not read at all.
   localparam logic [TW-1:0] TUSE_NONE = '1;
   localparam logic [1:0]    STG_LAST  = 2'(NSTAGE);

   logic [NREG-1:0]         r_pend;
   logic [NREG-1:0][TW-1:0] r_cnt;
   logic [NREG-1:0][1:0]    r_stg;
   logic [5:0]              r_busy;

   logic [NREG-1:0]         w_pend_nxt;
   logic [NREG-1:0][TW-1:0] w_cnt_nxt;
   logic [NREG-1:0][1:0]    w_stg_nxt;
   logic [5:0]              w_busy_nxt;

   logic w_hz_rs;
   logic w_hz_rt;
   logic w_issue;

   // A hazard exists when the producer's result will still not be forwardable
   // by the time this operand is consumed. id_valid leads every term so a
   // bubble with undriven operand fields resolves to a clean 0.
   assign w_hz_rs = id_valid && (id_rs != 5'd0) && (id_tuse_rs != TUSE_NONE)
                    && r_pend[id_rs] && (r_cnt[id_rs] > id_tuse_rs);
   assign w_hz_rt = id_valid && (id_rt != 5'd0) && (id_tuse_rt != TUSE_NONE)
                    && r_pend[id_rt] && (r_cnt[id_rt] > id_tuse_rt);
   assign stall   = w_hz_rs | w_hz_rt;

   // Tags are reported even while stalled so the muxes stay steady. A bubble
   // has no operands, so it reports GRF rather than propagating unknowns.
   assign fwd_rs_src = (id_valid && (id_rs != 5'd0) && r_pend[id_rs]) ? r_stg[id_rs] : 2'd0;
   assign fwd_rt_src = (id_valid && (id_rt != 5'd0) && r_pend[id_rt]) ? r_stg[id_rt] : 2'd0;

   // A stalled instruction becomes a bubble in E, so it must not be tracked.
   assign w_issue = id_valid && !stall && id_we && (id_dst != 5'd0);

   always_comb begin
      w_pend_nxt = r_pend;
      w_cnt_nxt  = r_cnt;
      w_stg_nxt  = r_stg;
      w_busy_nxt = '0;

      // Every tracked writer moves one stage per cycle; leaving W retires it.
      for (int i = 1; i < NREG; i++) begin
         if (r_pend[i]) begin
            if (r_stg[i] == STG_LAST) begin
               w_pend_nxt[i] = 1'b0;
               w_cnt_nxt[i]  = '0;
               w_stg_nxt[i]  = 2'd0;
            end else begin
               w_stg_nxt[i] = r_stg[i] + 2'd1;
               w_cnt_nxt[i] = (r_cnt[i] == '0) ? '0 : r_cnt[i] - TW'(1);
            end
         end
      end

      // The newest writer replaces any older one still in flight to the same
      // register, including one retiring this very edge.
      if (w_issue) begin
         w_pend_nxt[id_dst] = 1'b1;
         w_stg_nxt[id_dst]  = 2'd1;
         w_cnt_nxt[id_dst]  = id_tnew;
      end

      // $0 is hardwired; it never holds a pending writer.
      w_pend_nxt[0] = 1'b0;
      w_cnt_nxt[0]  = '0;
      w_stg_nxt[0]  = 2'd0;

      for (int i = 0; i < NREG; i++) begin
         w_busy_nxt = w_busy_nxt + 6'(w_pend_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_cnt  <= '0;
         r_stg  <= '0;
         r_busy <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         r_cnt  <= w_cnt_nxt;
         r_stg  <= w_stg_nxt;
         r_busy <= w_busy_nxt;
      end
   end

   assign busy_cnt = r_busy;

endmodule

// File: tb/tb_tuse_tnew_scoreboard.sv
module tb_tuse_tnew_scoreboard;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [1:0] id_tuse_rs;
   logic [1:0] id_tuse_rt;
   logic       id_we;
   logic [4:0] id_dst;
   logic [1:0] id_tnew;
   logic       stall;
   logic [1:0] fwd_rs_src;
   logic [1:0] fwd_rt_src;
   logic [5:0] busy_cnt;

   int checks   = 0;
   int failures = 0;

   tuse_tnew_scoreboard dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_tuse_rs (id_tuse_rs),
      .id_tuse_rt (id_tuse_rt),
      .id_we      (id_we),
      .id_dst     (id_dst),
      .id_tnew    (id_tnew),
      .stall      (stall),
      .fwd_rs_src (fwd_rs_src),
      .fwd_rt_src (fwd_rt_src),
      .busy_cnt   (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: for each register remember only the edge number at which
   // its most recent writer issued and that writer's Tnew. Everything else
   // (stage, remaining latency, pending) follows from the writer's age.
   int m_edge;
   int m_issue_edge [32];
   int m_tnew       [32];
   logic m_iss;

   function automatic void model_clear();
      m_edge = 0;
      for (int r = 0; r < 32; r++) begin
         m_issue_edge[r] = -1000;
         m_tnew[r]       = 0;
      end
   endfunction

   // Stage 1..3 while in E/M/W, 0 when nothing is in flight.
   function automatic int m_stage(input int r);
      int age;
      if (r == 0) return 0;
      age = m_edge - m_issue_edge[r] + 1;
      if (age >= 1 && age <= 3) return age;
      return 0;
   endfunction

   function automatic int m_remain(input int r);
      int s;
      int v;
      s = m_stage(r);
      if (s == 0) return 0;
      v = m_tnew[r] - (s - 1);
      return (v < 0) ? 0 : v;
   endfunction

   function automatic int m_stall();
      int h;
      h = 0;
      if (id_valid && id_tuse_rs != 2'd3 && m_stage(int'(id_rs)) != 0
          && m_remain(int'(id_rs)) > int'(id_tuse_rs)) h = 1;
      if (id_valid && id_tuse_rt != 2'd3 && m_stage(int'(id_rt)) != 0
          && m_remain(int'(id_rt)) > int'(id_tuse_rt)) h = 1;
      return h;
   endfunction

   function automatic int m_busy();
      int n;
      n = 0;
      for (int r = 1; r < 32; r++) if (m_stage(r) != 0) n++;
      return n;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge rst_n) model_clear();

   always @(posedge clk) begin
      if (rst_n) begin
         m_iss = id_valid && (m_stall() == 0) && id_we && (id_dst != 5'd0);
         m_edge++;
         if (m_iss) begin
            m_issue_edge[id_dst] = m_edge;
            m_tnew[id_dst]       = int'(id_tnew);
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_stall", int'(stall), 0);
         chk("rst_busy", int'(busy_cnt), 0);
         chk("rst_fwd_rs", int'(fwd_rs_src), 0);
      end else begin
         chk("stall", int'(stall), m_stall());
         chk("busy", int'(busy_cnt), m_busy());
         if (busy_cnt > 6'd3) chk("busy_max", int'(busy_cnt), 3);
         if (id_valid) begin
            chk("fwd_rs", int'(fwd_rs_src), m_stage(int'(id_rs)));
            chk("fwd_rt", int'(fwd_rt_src), m_stage(int'(id_rt)));
         end
      end
   end

   task automatic put(input logic v, input int rs, input int tur, input int rt, input int tut,
                      input logic we, input int dst, input int tn);
      id_valid   = v;
      id_rs      = 5'(rs);
      id_tuse_rs = 2'(tur);
      id_rt      = 5'(rt);
      id_tuse_rt = 2'(tut);
      id_we      = we;
      id_dst     = 5'(dst);
      id_tnew    = 2'(tn);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writer(input int dst, input int tn);
      tick(); put(1'b1, 0, 3, 0, 3, 1'b1, dst, tn);
   endtask

   task automatic drain();
      for (int k = 0; k < 5; k++) begin
         tick(); put(1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
      end
   endtask

   initial begin
      model_clear();
      rst_n = 1'b0;
      put(1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
      #2;
      chk("init_stall", int'(stall), 0);
      chk("init_busy", int'(busy_cnt), 0);
      tick(); rst_n = 1'b1;
      drain();
      chk("idle_stall", int'(stall), 0);
      chk("idle_fwd_rs", int'(fwd_rs_src), 0);
      chk("idle_busy", int'(busy_cnt), 0);

      // Load to $8 (Tnew=3), then a reader needing it one cycle after D.
      writer(8, 3); #2 chk("ld_issue_stall", int'(stall), 0);
      tick(); put(1'b1, 8, 1, 0, 3, 1'b0, 0, 0);
      #2 chk("ld_c1_stall", int'(stall), 1);
      chk("ld_c1_fwd", int'(fwd_rs_src), 1);
      chk("ld_c1_busy", int'(busy_cnt), 1);
      tick(); #2 chk("ld_c2_stall", int'(stall), 1);
      chk("ld_c2_fwd", int'(fwd_rs_src), 2);
      tick(); #2 chk("ld_c3_stall", int'(stall), 0);
      chk("ld_c3_fwd", int'(fwd_rs_src), 3);
      drain();

      // ALU result to $9 (Tnew=1) consumed by a branch in D (Tuse=0).
      writer(9, 1);
      tick(); put(1'b1, 9, 0, 0, 3, 1'b0, 0, 0);
      #2 chk("br_c1_stall", int'(stall), 1);
      tick(); #2 chk("br_c2_stall", int'(stall), 0);
      chk("br_c2_fwd", int'(fwd_rs_src), 2);
      drain();

      // Back-to-back writers to $10: only the newest one counts.
      writer(10, 3);
      writer(10, 1); #2 chk("b2b_w2_stall", int'(stall), 0);
      tick(); put(1'b1, 10, 1, 0, 3, 1'b0, 0, 0);
      #2 chk("b2b_rd_stall", int'(stall), 0);
      chk("b2b_rd_fwd", int'(fwd_rs_src), 1);
      chk("b2b_rd_busy", int'(busy_cnt), 1);
      drain();

      // $0 is never tracked; an unused operand never stalls but keeps its tag.
      writer(0, 3);
      tick(); put(1'b1, 0, 0, 0, 0, 1'b0, 0, 0);
      #2 chk("r0_stall", int'(stall), 0);
      chk("r0_fwd", int'(fwd_rs_src), 0);
      chk("r0_busy", int'(busy_cnt), 0);
      writer(11, 3);
      tick(); put(1'b1, 11, 3, 0, 3, 1'b0, 0, 0);
      #2 chk("nouse_stall", int'(stall), 0);
      chk("nouse_fwd", int'(fwd_rs_src), 1);
      tick(); put(1'b1, 11, 3, 11, 0, 1'b0, 0, 0);
      #2 chk("same_stall", int'(stall), 1);
      chk("same_fwd_rs", int'(fwd_rs_src), 2);
      chk("same_fwd_rt", int'(fwd_rt_src), 2);
      drain();

      // Stream of writers to distinct registers: occupancy saturates at 3.
      writer(12, 2); writer(13, 2); writer(14, 2);
      writer(15, 2); #2 chk("strm_busy_a", int'(busy_cnt), 3);
      tick(); put(1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
      #2 chk("strm_busy_b", int'(busy_cnt), 3);
      tick(); #2 chk("strm_busy_c", int'(busy_cnt), 2);
      tick(); #2 chk("strm_busy_d", int'(busy_cnt), 1);
      tick(); #2 chk("strm_busy_e", int'(busy_cnt), 0);
      drain();

      // Asynchronous reset with two writers in flight and a stalled reader.
      writer(16, 3); writer(17, 3);
      tick(); put(1'b1, 17, 0, 0, 3, 1'b0, 0, 0);
      #2 chk("ar_pre_busy", int'(busy_cnt), 2);
      chk("ar_pre_stall", int'(stall), 1);
      #1 rst_n = 1'b0;
      #1 chk("ar_stall", int'(stall), 0);
      chk("ar_busy", int'(busy_cnt), 0);
      chk("ar_fwd", int'(fwd_rs_src), 0);
      tick(); rst_n = 1'b1;
      tick(); #2 chk("ar_post_stall", int'(stall), 0);
      drain();

      // Randomized traffic, biased to a few registers so hazards are common.
      for (int i = 0; i < 1500; i++) begin
         tick();
         put(($urandom_range(0, 9) < 8),
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5),
             $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5),
             $urandom_range(0, 3),
             ($urandom_range(0, 9) < 6),
             $urandom_range(0, 5),
             $urandom_range(0, 3));
         if (i % 400 == 399) begin
            #2 rst_n = 1'b0;
            tick(); rst_n = 1'b1;
         end
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
